// File: rtl/beam_power_integrator_pkg.sv
// Shared width helpers and the complex-sample type for the beam power integrator.
package beam_power_integrator_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] i;
    logic signed [SAMPLE_W-1:0] q;
  } cplx_t;

  function automatic int prod_width(input int wl);
    return 2 * wl + 1;
  endfunction

  function automatic int calc_width(input int wl, input int n_ch);
    return prod_width(wl) + $clog2(n_ch);
  endfunction

  function automatic int pow_width(input int wl, input int n_ch);
    return 2 * calc_width(wl, n_ch);
  endfunction

  function automatic int acc_width(input int wl, input int n_ch, input int log2_avg);
    return pow_width(wl, n_ch) + log2_avg;
  endfunction

endpackage

// File: rtl/beam_power_integrator_cmul_reg.sv
// Registered complex multiplier: captures x and c together, then registers x*c.
// Capturing the coefficient with the sample keeps a same-edge coefficient write out of this snapshot.
module beam_power_integrator_cmul_reg
  import beam_power_integrator_pkg::*;
#(
  parameter int WL = 16,
  localparam int PW = prod_width(WL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [WL-1:0] x_i,
  input  logic signed [WL-1:0] x_q,
  input  logic signed [WL-1:0] c_i,
  input  logic signed [WL-1:0] c_q,
  output logic signed [PW-1:0] p_i,
  output logic signed [PW-1:0] p_q
);

  logic signed [WL-1:0] x_re_q, x_im_q, c_re_q, c_im_q;
  logic signed [WL-1:0] x_re_d, x_im_d, c_re_d, c_im_d;
  logic signed [PW-1:0] p_re_q, p_im_q, p_re_d, p_im_d;
  logic signed [PW-1:0] xr_s, xi_s, cr_s, ci_s;

  assign xr_s = PW'(x_re_q);
  assign xi_s = PW'(x_im_q);
  assign cr_s = PW'(c_re_q);
  assign ci_s = PW'(c_im_q);

  // operand capture and product stage, both held while en is low
  always_comb begin
    x_re_d = x_re_q;
    x_im_d = x_im_q;
    c_re_d = c_re_q;
    c_im_d = c_im_q;
    p_re_d = p_re_q;
    p_im_d = p_im_q;
    if (en) begin
      x_re_d = x_i;
      x_im_d = x_q;
      c_re_d = c_i;
      c_im_d = c_q;
      p_re_d = xr_s * cr_s - xi_s * ci_s;
      p_im_d = xr_s * ci_s + xi_s * cr_s;
    end else begin
      p_re_d = p_re_q;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_re_q <= '0;
      x_im_q <= '0;
      c_re_q <= '0;
      c_im_q <= '0;
      p_re_q <= '0;
      p_im_q <= '0;
    end else begin
      x_re_q <= x_re_d;
      x_im_q <= x_im_d;
      c_re_q <= c_re_d;
      c_im_q <= c_im_d;
      p_re_q <= p_re_d;
      p_im_q <= p_im_d;
    end
  end

  assign p_i = p_re_q;
  assign p_q = p_im_q;

endmodule

// File: rtl/beam_power_integrator.sv
// Steered beam power: per-channel complex multiply by a loadable steering vector,
// coherent sum, |sum|^2, then integration of 2^LOG2_AVG snapshots per output.
module beam_power_integrator
  import beam_power_integrator_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int N_CH        = 4,
  parameter int LOG2_AVG    = 4,
  localparam int ACC_W      = acc_width(WORD_LENGTH, N_CH, LOG2_AVG),
  localparam int AW         = $clog2(N_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [N_CH*WORD_LENGTH-1:0]   s_i,
  input  logic [N_CH*WORD_LENGTH-1:0]   s_q,
  input  logic                          coef_we,
  input  logic [AW-1:0]                 coef_addr,
  input  logic signed [WORD_LENGTH-1:0] coef_i,
  input  logic signed [WORD_LENGTH-1:0] coef_q,
  input  logic                          frame_restart,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [ACC_W-1:0]              m_power
);

  localparam int PW    = prod_width(WORD_LENGTH);
  localparam int WLC   = calc_width(WORD_LENGTH, N_CH);
  localparam int POW_W = pow_width(WORD_LENGTH, N_CH);
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  logic signed [WORD_LENGTH-1:0] coef_re_q [N_CH];
  logic signed [WORD_LENGTH-1:0] coef_im_q [N_CH];
  logic signed [WORD_LENGTH-1:0] coef_re_d [N_CH];
  logic signed [WORD_LENGTH-1:0] coef_im_d [N_CH];
  logic signed [PW-1:0]          p_re_s [N_CH];
  logic signed [PW-1:0]          p_im_s [N_CH];

  logic signed [WLC-1:0]   i_tot_q, q_tot_q, i_tot_d, q_tot_d;
  logic signed [POW_W-1:0] i_ext_s, q_ext_s;
  logic [POW_W-1:0]        pow_q, pow_d;
  logic [ACC_W-1:0]        acc_q, acc_d, acc_sum_s, m_power_q, m_power_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              vld_q, vld_d;
  logic                    m_valid_q, m_valid_d;
  logic                    advance_s, accept_s;

  assign advance_s = !rst && (!m_valid_q || m_ready);
  assign accept_s  = s_valid && advance_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    beam_power_integrator_cmul_reg #(.WL(WORD_LENGTH)) u_cmul (
      .clk (clk),
      .rst (rst),
      .en  (advance_s),
      .x_i (s_i[g*WORD_LENGTH +: WORD_LENGTH]),
      .x_q (s_q[g*WORD_LENGTH +: WORD_LENGTH]),
      .c_i (coef_re_q[g]),
      .c_q (coef_im_q[g]),
      .p_i (p_re_s[g]),
      .p_q (p_im_s[g])
    );
  end

  // steering coefficient bank; out-of-range addresses match no entry
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      if (coef_we && (coef_addr == AW'(k))) begin
        coef_re_d[k] = coef_i;
        coef_im_d[k] = coef_q;
      end else begin
        coef_re_d[k] = coef_re_q[k];
        coef_im_d[k] = coef_im_q[k];
      end
    end
  end

  assign i_ext_s = POW_W'(i_tot_q);
  assign q_ext_s = POW_W'(q_tot_q);

  // adder tree and squaring stages, full precision throughout
  always_comb begin
    i_tot_d = i_tot_q;
    q_tot_d = q_tot_q;
    pow_d   = pow_q;
    if (advance_s) begin
      i_tot_d = '0;
      q_tot_d = '0;
      for (int k = 0; k < N_CH; k++) begin
        i_tot_d = i_tot_d + WLC'(p_re_s[k]);
        q_tot_d = q_tot_d + WLC'(p_im_s[k]);
      end
      pow_d = $unsigned(i_ext_s * i_ext_s + q_ext_s * q_ext_s);
    end else begin
      pow_d = pow_q;
    end
  end

  assign acc_sum_s = acc_q + ACC_W'(pow_q);

  // stage valids, integration and output handshake
  always_comb begin
    vld_d     = vld_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    m_power_d = m_power_q;
    m_valid_d = m_valid_q && !m_ready;
    if (frame_restart) begin
      vld_d = {3'b000, accept_s};
      acc_d = '0;
      cnt_d = '0;
    end else if (advance_s) begin
      vld_d = {vld_q[2:0], accept_s};
      if (vld_q[3] && (cnt_q == CNT_LAST)) begin
        acc_d     = '0;
        cnt_d     = '0;
        m_valid_d = 1'b1;
        m_power_d = acc_sum_s;
      end else if (vld_q[3]) begin
        acc_d = acc_sum_s;
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        acc_d = acc_q;
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        coef_re_q[k] <= '0;
        coef_im_q[k] <= '0;
      end
      i_tot_q   <= '0;
      q_tot_q   <= '0;
      pow_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      vld_q     <= 4'b0000;
      m_valid_q <= 1'b0;
      m_power_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        coef_re_q[k] <= coef_re_d[k];
        coef_im_q[k] <= coef_im_d[k];
      end
      i_tot_q   <= i_tot_d;
      q_tot_q   <= q_tot_d;
      pow_q     <= pow_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      m_valid_q <= m_valid_d;
      m_power_q <= m_power_d;
    end
  end

  assign s_ready = advance_s;
  assign m_valid = m_valid_q;
  assign m_power = m_power_q;

endmodule

// File: tb/tb_beam_power_integrator.sv
// Bench for beam_power_integrator: vector table, directed corner sequences and a
// randomized phase checked by a snapshot-level scoreboard model.
module tb_beam_power_integrator;
  import beam_power_integrator_pkg::*;

  localparam int WL   = 16;
  localparam int NCH  = 4;
  localparam int L2   = 2;
  localparam int ACCW = acc_width(WL, NCH, L2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic                 s_valid = 1'b0, coef_we = 1'b0, frame_restart = 1'b0, m_ready = 1'b1;
  logic                 s_ready, m_valid;
  logic [NCH*WL-1:0]    s_i = '0, s_q = '0;
  logic [1:0]           coef_addr = 2'd0;
  logic signed [WL-1:0] coef_i = '0, coef_q = '0;
  logic [ACCW-1:0]      m_power;

  beam_power_integrator #(.WORD_LENGTH(WL), .N_CH(NCH), .LOG2_AVG(L2)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_i(coef_i), .coef_q(coef_q),
    .frame_restart(frame_restart), .m_valid(m_valid), .m_ready(m_ready), .m_power(m_power)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model: whole snapshots, not pipeline stages ----------------
  int              mc_re [NCH];
  int              mc_im [NCH];
  logic [ACCW-1:0] infl_pow [$];
  int              infl_age [$];
  logic [ACCW-1:0] exp_q [$];
  logic [127:0]    macc = '0;
  int              mcnt = 0;
  logic            hold_prev = 1'b0;
  logic [ACCW-1:0] hold_pow = '0;

  function automatic logic [ACCW-1:0] snap_pow();
    longint it = 0, qt = 0, ai, aq;
    logic [127:0] p;
    for (int k = 0; k < NCH; k++) begin
      longint xr = longint'($signed(s_i[k*WL +: WL]));
      longint xm = longint'($signed(s_q[k*WL +: WL]));
      it += xr * mc_re[k] - xm * mc_im[k];
      qt += xr * mc_im[k] + xm * mc_re[k];
    end
    ai = (it < 0) ? -it : it;
    aq = (qt < 0) ? -qt : qt;
    p  = 128'(ai) * 128'(ai) + 128'(aq) * 128'(aq);
    return p[ACCW-1:0];
  endfunction

  initial begin
    for (int k = 0; k < NCH; k++) begin mc_re[k] = 0; mc_im[k] = 0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        check("s_ready_in_reset", s_ready, 1'b0);
        infl_pow.delete(); infl_age.delete(); exp_q.delete();
        macc = '0; mcnt = 0; hold_prev = 1'b0;
        for (int k = 0; k < NCH; k++) begin mc_re[k] = 0; mc_im[k] = 0; end
      end else begin
        logic acc_ok;
        logic [ACCW-1:0] p;
        check("s_ready_rule", s_ready, !m_valid || m_ready);
        if (hold_prev) begin
          check("hold_valid", m_valid, 1'b1);
          check("hold_power", m_power, hold_pow);
        end
        hold_prev = m_valid && !m_ready;
        hold_pow  = m_power;
        if (m_valid && m_ready) begin
          check("sb_output_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check("sb_power", m_power, exp_q.pop_front());
        end
        acc_ok = s_valid && s_ready;
        p = snap_pow();
        if (frame_restart) begin
          infl_pow.delete(); infl_age.delete();
          macc = '0; mcnt = 0;
          if (acc_ok) begin infl_pow.push_back(p); infl_age.push_back(0); end
        end else if (s_ready) begin
          if (infl_age.size() > 0 && infl_age[0] == 3) begin
            macc += 128'(infl_pow.pop_front());
            void'(infl_age.pop_front());
            mcnt++;
            if (mcnt == (1 << L2)) begin
              exp_q.push_back(macc[ACCW-1:0]);
              macc = '0; mcnt = 0;
            end
          end
          foreach (infl_age[j]) infl_age[j]++;
          if (acc_ok) begin infl_pow.push_back(p); infl_age.push_back(0); end
        end
        if (coef_we && int'(coef_addr) < NCH) begin
          mc_re[coef_addr] = int'(coef_i);
          mc_im[coef_addr] = int'(coef_q);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_chan(input int k, input int xr, input int xm);
    s_i[k*WL +: WL] = WL'(xr);
    s_q[k*WL +: WL] = WL'(xm);
  endtask

  task automatic set_all(input int xr, input int xm);
    for (int k = 0; k < NCH; k++) set_chan(k, xr, xm);
  endtask

  task automatic load_coefs(input int cr, input int cm);
    for (int k = 0; k < NCH; k++) begin
      coef_we = 1'b1; coef_addr = 2'(k); coef_i = WL'(cr); coef_q = WL'(cm);
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic send_snap();
    logic a;
    int t;
    a = 1'b0;
    s_valid = 1'b1;
    for (t = 0; t < 50 && !a; t++) begin
      @(negedge clk);
      a = s_ready;
      tick();
    end
    s_valid = 1'b0;
    if (!a) check("send_timeout", a, 1'b1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!m_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    cplx_t           x;
    cplx_t           c;
    logic [ACCW-1:0] expv;
  } vec_t;

  function automatic vec_t mk(input int xr, input int xm, input int cr, input int cm,
                              input logic [ACCW-1:0] e);
    vec_t v;
    v.x.i = WL'(xr); v.x.q = WL'(xm); v.c.i = WL'(cr); v.c.q = WL'(cm); v.expv = e;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    int lat;
    logic [ACCW-1:0] pa;
    vecs[0] = mk(1, 0, 32767, 0, 72'd4 * 72'd131068 * 72'd131068);
    vecs[1] = mk(-32768, 0, -32768, 0, 72'd1 << 66);
    vecs[2] = mk(1, 1, 1, 0, 72'd128);
    vecs[3] = mk(0, 1, 0, 1, 72'd64);
    vecs[4] = mk(100, -200, 3, 4, 72'd80000000);
    vecs[5] = mk(-32768, -32768, -32768, 32767,
                 72'd4 * (72'd8589803520 * 72'd8589803520 + 72'd131072 * 72'd131072));

    // reset state
    repeat (3) tick();
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_m_power", m_power, '0);
    check("reset_s_ready", s_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", s_ready, 1'b1);

    // vector table: 4 identical snapshots per entry
    for (int v = 0; v < 6; v++) begin
      load_coefs(int'(vecs[v].c.i), int'(vecs[v].c.q));
      set_all(int'(vecs[v].x.i), int'(vecs[v].x.q));
      repeat (4) send_snap();
      wait_out(lat);
      check($sformatf("vec%0d_latency", v), lat, 4);
      check($sformatf("vec%0d_power", v), m_power, vecs[v].expv);
      repeat (2) tick();
    end

    // backpressure: stalled output, pending snapshot must survive
    load_coefs(32767, 0);
    for (int k = 0; k < NCH; k++) set_chan(k, $urandom, $urandom);
    m_ready = 1'b0;
    repeat (4) send_snap();
    wait_out(lat);
    check("bp_latency", lat, 4);
    pa = m_power;
    set_all(1, 0);
    s_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      check("bp_s_ready_low", s_ready, 1'b0);
      check("bp_m_power_stable", m_power, pa);
    end
    m_ready = 1'b1;
    repeat (4) send_snap();
    wait_out(lat);
    check("bp_next_latency", lat, 4);
    check("bp_next_power", m_power, 72'd4 * 72'd131068 * 72'd131068);
    repeat (2) tick();

    // frame_restart together with an accepted snapshot
    set_all(5, 5);
    repeat (2) send_snap();
    set_all(1, 0);
    frame_restart = 1'b1;
    send_snap();
    frame_restart = 1'b0;
    repeat (3) send_snap();
    wait_out(lat);
    check("restart_latency", lat, 4);
    check("restart_power", m_power, 72'd4 * 72'd131068 * 72'd131068);
    repeat (2) tick();

    // coefficient write between snapshots 2 and 3
    repeat (2) send_snap();
    coef_we = 1'b1; coef_addr = 2'd2; coef_i = 16'sd0; coef_q = 16'sd32767;
    tick();
    coef_we = 1'b0;
    repeat (2) send_snap();
    wait_out(lat);
    check("coefw_power", m_power, 72'd2 * 72'd131068 * 72'd131068
          + 72'd2 * (72'd98301 * 72'd98301 + 72'd32767 * 72'd32767));
    repeat (2) tick();

    // reset mid-frame; a coefficient write during reset is lost
    load_coefs(32767, 0);
    repeat (3) send_snap();
    rst = 1'b1;
    coef_we = 1'b1; coef_addr = 2'd0; coef_i = 16'sd100; coef_q = 16'sd0;
    tick();
    coef_we = 1'b0;
    tick();
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_m_power", m_power, '0);
    rst = 1'b0;
    tick();
    repeat (4) send_snap();
    wait_out(lat);
    check("postrst_latency", lat, 4);
    check("postrst_zero_power", m_power, '0);
    repeat (2) tick();
    load_coefs(32767, 0);
    repeat (4) send_snap();
    wait_out(lat);
    check("postrst_reload_power", m_power, 72'd4 * 72'd131068 * 72'd131068);
    repeat (2) tick();

    // randomized traffic against the scoreboard
    for (int t = 0; t < 600; t++) begin
      s_valid       = ($urandom_range(0, 3) != 0);
      m_ready       = ($urandom_range(0, 3) != 0);
      coef_we       = ($urandom_range(0, 11) == 0);
      coef_addr     = 2'($urandom_range(0, 3));
      coef_i        = WL'($urandom);
      coef_q        = WL'($urandom);
      frame_restart = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < NCH; k++) set_chan(k, $urandom, $urandom);
      tick();
    end
    s_valid = 1'b0; coef_we = 1'b0; frame_restart = 1'b0; m_ready = 1'b1;
    repeat (20) tick();
    check("drain_no_pending", exp_q.size(), 0);
    check("drain_m_valid", m_valid, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
